vecmul_stream: RTL and testbench

Streaming successor to the single-shot masked vector multiplier. It computes bias + Σ nodes[i]·weights[i] over a vector of NUM_NODES binary nodes that arrives LANES nodes per beat under valid/ready flow control. The result is held in a saturating (or wrapping) accumulator of PRECISION_BITS+OVERFLOW_BITS bits. It sits between the weight-memory reader and the sigmoid/sampling stage of the RBM datapath, so large layers no longer need one full-width adder tree per hidden node.

---
 rtl/vecmul_stream.sv | 148 ++++++++++++++
 tb/tb_vecmul_stream.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/vecmul_stream.sv
// Streaming masked dot product: bias + sum(nodes[i]*weights[i]), LANES nodes per beat,
// three-stage pipeline (lane capture, lane sum, accumulate) with saturating or wrapping acc.

module vecmul_stream_lane #(
    parameter int PRECISION_BITS = 32,
    parameter int LANE_IDX       = 0,
    parameter int NUM_NODES      = 64
) (
    input  logic                      node_i,
    input  logic [31:0]               base_i,
    input  logic [PRECISION_BITS-1:0] w_i,
    output logic [PRECISION_BITS-1:0] w_o
);
    localparam logic [31:0] LIDX = 32'(LANE_IDX);
    localparam logic [31:0] NN   = 32'(NUM_NODES);

    // Lanes past the end of the vector on the final beat never contribute.
    assign w_o = (node_i && ((base_i + LIDX) < NN)) ? w_i : '0;
endmodule

module vecmul_stream #(
    parameter int PRECISION_BITS = 32,
    parameter int NUM_NODES      = 64,
    parameter int LANES          = 8,
    parameter int OVERFLOW_BITS  = 8,
    parameter int SATURATE       = 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start,
    input  logic signed [PRECISION_BITS-1:0]              bias,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    input  logic [LANES-1:0]                              nodes,
    input  logic [PRECISION_BITS*LANES-1:0]               weights,
    output logic                                          out_valid,
    input  logic                                          out_ready,
    output logic signed [PRECISION_BITS+OVERFLOW_BITS-1:0] product,
    output logic                                          overflow
);
    localparam int PAD_BITS = PRECISION_BITS + OVERFLOW_BITS;
    localparam int BEATS    = (NUM_NODES + LANES - 1) / LANES;
    localparam int CNT_W    = $clog2(BEATS + 1);
    localparam int STAGES   = 2;

    localparam logic [PAD_BITS-1:0] ACC_MAX = {1'b0, {(PAD_BITS-1){1'b1}}};
    localparam logic [PAD_BITS-1:0] ACC_MIN = {1'b1, {(PAD_BITS-1){1'b0}}};

    if (OVERFLOW_BITS < $clog2(LANES) + 1) begin : g_bad_cfg
        $error("vecmul_stream: OVERFLOW_BITS must be >= clog2(LANES)+1");
    end

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t                                     state_q, state_d;
    logic [CNT_W-1:0]                           beat_cnt_q;
    logic [LANES-1:0][PRECISION_BITS-1:0]       lane_w_q, lane_w_d;
    logic [PAD_BITS-1:0]                        lane_sum_q, lane_sum_d;
    logic [PAD_BITS-1:0]                        acc_q, acc_d;
    logic                                       ovf_q, ovf_step;
    logic [PAD_BITS:0]                          sum_ext;
    logic [STAGES:1]                            vld_q, last_q;
    logic [STAGES:0]                            vld_pipe, last_pipe;
    logic [31:0]                                base;
    logic                                       fire;

    assign in_ready  = (state_q == ACCUM) && (beat_cnt_q < CNT_W'(BEATS));
    assign out_valid = (state_q == DONE);
    assign product   = acc_q;
    assign overflow  = ovf_q;

    assign fire      = in_valid && in_ready;
    assign base      = 32'(beat_cnt_q) * 32'(LANES);
    assign vld_pipe  = {vld_q, fire};
    assign last_pipe = {last_q, (beat_cnt_q == CNT_W'(BEATS - 1))};

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        vecmul_stream_lane #(
            .PRECISION_BITS(PRECISION_BITS),
            .LANE_IDX      (j),
            .NUM_NODES     (NUM_NODES)
        ) u_lane (
            .node_i(nodes[j]),
            .base_i(base),
            .w_i   (weights[PRECISION_BITS*j +: PRECISION_BITS]),
            .w_o   (lane_w_d[j])
        );
    end

    always_comb begin
        lane_sum_d = '0;
        for (int j = 0; j < LANES; j++)
            lane_sum_d = lane_sum_d + {{OVERFLOW_BITS{lane_w_q[j][PRECISION_BITS-1]}}, lane_w_q[j]};
    end

    // One guard bit exposes signed overflow as a mismatch of the top two bits.
    always_comb begin
        sum_ext  = {acc_q[PAD_BITS-1], acc_q} + {lane_sum_q[PAD_BITS-1], lane_sum_q};
        ovf_step = sum_ext[PAD_BITS] ^ sum_ext[PAD_BITS-1];
        acc_d    = sum_ext[PAD_BITS-1:0];
        if (ovf_step && (SATURATE != 0))
            acc_d = sum_ext[PAD_BITS] ? ACC_MIN : ACC_MAX;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ACCUM;
            ACCUM:   if (vld_pipe[STAGES] && last_pipe[STAGES]) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_q <= '0;
            lane_w_q   <= '0;
            lane_sum_q <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            vld_q      <= '0;
            last_q     <= '0;
        end else begin
            vld_q  <= vld_pipe[STAGES-1:0];
            last_q <= last_pipe[STAGES-1:0];
            if (fire) begin
                lane_w_q   <= lane_w_d;
                beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            end
            if (vld_pipe[1])
                lane_sum_q <= lane_sum_d;
            if (state_q == IDLE && start) begin
                acc_q      <= {{OVERFLOW_BITS{bias[PRECISION_BITS-1]}}, bias};
                ovf_q      <= 1'b0;
                beat_cnt_q <= '0;
            end else if (vld_pipe[STAGES]) begin
                acc_q <= acc_d;
                ovf_q <= ovf_q | ovf_step;
            end
        end
    end
endmodule

// File: tb/tb_vecmul_stream.sv
// Directed bench for vecmul_stream: small 6-node/4-lane instance plus two 64-node
// instances (saturating and wrapping) driven with identical overflow stimulus.

module tb_vecmul_stream;
    logic              clk = 1'b0;
    logic              rst;
    logic              start, in_valid, out_ready;
    logic signed [7:0] bias;
    logic [3:0]        nodes;
    logic [31:0]       weights;
    logic              in_ready, out_valid, overflow;
    logic [11:0]       product;

    logic              b_start, b_in_valid, b_out_ready;
    logic signed [7:0] b_bias;
    logic [7:0]        b_nodes;
    logic [63:0]       b_weights;
    logic              s_in_ready, s_out_valid, s_overflow;
    logic [11:0]       s_product;
    logic              w_in_ready, w_out_valid, w_overflow;
    logic [11:0]       w_product;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vecmul_stream #(.PRECISION_BITS(8), .NUM_NODES(6), .LANES(4), .OVERFLOW_BITS(4), .SATURATE(1)) dut (
        .clk(clk), .rst(rst), .start(start), .bias(bias), .in_valid(in_valid), .in_ready(in_ready),
        .nodes(nodes), .weights(weights), .out_valid(out_valid), .out_ready(out_ready),
        .product(product), .overflow(overflow));

    vecmul_stream #(.PRECISION_BITS(8), .NUM_NODES(64), .LANES(8), .OVERFLOW_BITS(4), .SATURATE(1)) dut_sat (
        .clk(clk), .rst(rst), .start(b_start), .bias(b_bias), .in_valid(b_in_valid), .in_ready(s_in_ready),
        .nodes(b_nodes), .weights(b_weights), .out_valid(s_out_valid), .out_ready(b_out_ready),
        .product(s_product), .overflow(s_overflow));

    vecmul_stream #(.PRECISION_BITS(8), .NUM_NODES(64), .LANES(8), .OVERFLOW_BITS(4), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst(rst), .start(b_start), .bias(b_bias), .in_valid(b_in_valid), .in_ready(w_in_ready),
        .nodes(b_nodes), .weights(b_weights), .out_valid(w_out_valid), .out_ready(b_out_ready),
        .product(w_product), .overflow(w_overflow));

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    task automatic start_vec(input logic signed [7:0] b);
        start = 1'b1; bias = b;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] n, input logic [31:0] w);
        int k = 0;
        nodes = n; weights = w; in_valid = 1'b1;
        while (!in_ready && k < 20) begin @(negedge clk); k++; end
        if (k >= 20) chk("beat_ready_timeout", 64'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic get_result(input string tag, input logic signed [63:0] ep, input logic signed [63:0] eo);
        int k = 0;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        chk({tag, "_valid"}, 64'(out_valid), 1);
        chk({tag, "_prod"}, $signed(product), ep);
        chk({tag, "_ovf"}, 64'(overflow), eo);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, "_drop"}, 64'(out_valid), 0);
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; bias = '0; in_valid = 1'b0; nodes = '0; weights = '0; out_ready = 1'b0;
        b_start = 1'b0; b_bias = '0; b_in_valid = 1'b0; b_nodes = '0; b_weights = '0; b_out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_product", $signed(product), 0);
        chk("rst_overflow", 64'(overflow), 0);
        rst = 1'b0;
        @(negedge clk);

        // Basic: 1+2+3+4+5+6, lanes 2-3 of beat 1 lie past NUM_NODES.
        start_vec(8'sd0);
        send_beat(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1});
        send_beat(4'b1111, {8'd8, 8'd7, 8'd6, 8'd5});
        chk("basic_lat_t0", 64'(out_valid), 0);
        @(negedge clk);
        chk("basic_lat_t1", 64'(out_valid), 0);
        @(negedge clk);
        chk("basic_lat_t2", 64'(out_valid), 1);
        get_result("basic", 21, 0);

        // Masking and signed weights: -10 -128 +127 +50 +9.
        start_vec(-8'sd10);
        send_beat(4'b1011, {8'h32, 8'hFF, 8'h7F, 8'h80});
        send_beat(4'b0010, {8'hAA, 8'h55, 8'h09, 8'hF9});
        get_result("mask", 48, 0);

        // Repeated vectors must not carry anything over: 127 + 6*127 each time.
        for (int v = 0; v < 20; v++) begin
            start_vec(8'sd127);
            send_beat(4'b1111, {4{8'd127}});
            send_beat(4'b1111, {4{8'd127}});
            get_result("rep889", 889, 0);
        end

        // Flow control: beat, two idle cycles, beat; start pulses in ACCUM/DONE ignored.
        start_vec(8'sd0);
        send_beat(4'b1111, {8'd4, 8'd3, 8'd2, 8'd1});
        start = 1'b1; bias = 8'sd100;
        @(negedge clk);
        start = 1'b0;
        chk("flow_ready_stall", 64'(in_ready), 1);
        @(negedge clk);
        send_beat(4'b1111, {8'd8, 8'd7, 8'd6, 8'd5});
        k = 0;
        while (!out_valid && k < 20) begin @(negedge clk); k++; end
        for (int c = 0; c < 10; c++) begin
            chk("flow_hold_valid", 64'(out_valid), 1);
            chk("flow_hold_prod", $signed(product), 21);
            chk("flow_hold_ovf", 64'(overflow), 0);
            start = (c == 3); bias = 8'sd50;
            @(negedge clk);
        end
        start = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("flow_idle_valid", 64'(out_valid), 0);
        chk("flow_idle_ready", 64'(in_ready), 0);

        // Reset after beat 0 of a vector is accepted.
        start_vec(8'sd5);
        chk("restart_ready", 64'(in_ready), 1);
        send_beat(4'b1111, {4{8'd100}});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_in_ready", 64'(in_ready), 0);
        chk("abort_out_valid", 64'(out_valid), 0);
        chk("abort_product", $signed(product), 0);
        chk("abort_overflow", 64'(overflow), 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("abort_no_pulse", 64'(out_valid), 0);
        end
        start_vec(8'sd0);
        send_beat(4'b1111, {4{8'd1}});
        send_beat(4'b0011, {8'd9, 8'd9, 8'd2, 8'd2});
        get_result("post_abort", 8, 0);

        // 64 nodes of 127 plus bias 127 = 8255: clamps to 2047, wraps to 63.
        b_start = 1'b1; b_bias = 8'sd127;
        @(negedge clk);
        b_start = 1'b0; b_in_valid = 1'b1; b_nodes = 8'hFF; b_weights = {8{8'd127}};
        repeat (8) @(negedge clk);
        b_in_valid = 1'b0;
        k = 0;
        while (!s_out_valid && k < 20) begin @(negedge clk); k++; end
        chk("sat_valid", 64'(s_out_valid), 1);
        chk("sat_prod", $signed(s_product), 2047);
        chk("sat_ovf", 64'(s_overflow), 1);
        chk("wrap_valid", 64'(w_out_valid), 1);
        chk("wrap_prod", $signed(w_product), 63);
        chk("wrap_ovf", 64'(w_overflow), 1);
        b_out_ready = 1'b1;
        @(negedge clk);
        b_out_ready = 1'b0;
        chk("sat_drop", 64'(s_out_valid), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
